spram_port_arbiter: RTL
=======================

// Module: spram_port_arbiter
// PURPOSE
//  Shares one single-port spram512x40/1024x20/2048x10 macro between two requesters (port 0, port 1).
//  One access (read or write) per cycle; round-robin grant with optional burst lock.
//  Tags each read through the macro's read latency and steers the returned data to its owner.
//  Sits between client logic and the spram instance; drives clk-domain addr/datain/we directly.
// PARAMETERS
//  ADDR_W        9   address width (9/10/11 for 512x40/1024x20/2048x10)
//  DATA_W        40  data width (40/20/10)
//  RD_LAT        1   macro read latency in cycles (1..4); dataout valid RD_LAT cycles after read issue
// PORTS
//  clk           in   1       single clock; all state on rising edge
//  reset_n       in   1       asynchronous, active-low reset
//  req_valid     in   2       per-port request valid ([0]=port 0)
//  req_ready     out  2       per-port grant; transfer when valid&ready
//  req_we        in   2       1=write, 0=read
//  req_lock      in   2       keep grant after this transfer (burst)
//  req_addr      in   2*ADDR_W  per-port address, port 0 in LSBs
//  req_wdata     in   2*DATA_W  per-port write data, port 0 in LSBs
//  rsp_valid     out  2       one-cycle pulse: read data for that port on rsp_rdata
//  rsp_rdata     out  DATA_W  read data (shared bus, qualified by rsp_valid)
//  mem_addr      out  ADDR_W  to macro addr
//  mem_datain    out  DATA_W  to macro datain
//  mem_we        out  1       to macro we
//  mem_dataout   in   DATA_W  from macro dataout
// BEHAVIOUR
//  Reset: req_ready=0, rsp_valid=0, mem_we=0, mem_addr=0, mem_datain=0, rr_ptr=0 (port 0 favoured),
//   FSM=ARB, tag pipeline cleared. Reset mid-burst or mid-read drops everything; no rsp_valid after.
//  Grant is combinational from req_valid and state; mem_* are combinational from the granted port
//   (mem_we = granted & req_we[g]); with no grant mem_we=0 and mem_addr/mem_datain hold last value.
//  FSM ARB: both valid -> grant port rr_ptr; one valid -> grant it; none -> idle.
//   On transfer: rr_ptr <= ~g; if req_lock[g] -> LOCK(g), else stay ARB.
//  FSM LOCK(g): only port g may be granted; other port req_ready=0 even if valid.
//   Transfer with req_lock[g]=0 -> ARB. req_valid[g]=0 for a cycle -> stay LOCK (lock is held
//   by the flag, not by valid). rr_ptr not updated while locked except on final transfer.
//  Lock starvation guard: 16-cycle counter in LOCK; at 16 consecutive locked cycles with other port
//   valid, force ARB and grant other port next; counter clears on entering LOCK.
//  Reads: transfer with req_we=0 pushes {valid=1,port=g} into an RD_LAT-deep shift register;
//   at its output rsp_valid[port]=1 for one cycle, rsp_rdata=mem_dataout. No response backpressure.
//  Writes produce no response. Write then read same address on consecutive cycles returns new data.
//  Back-to-back reads every cycle sustained (full throughput); responses in issue order.
//  req_valid dropped without transfer is legal; no state changes.
// STRUCTURE
//  Package spram_arb_pkg: typedef arb_state_e {ARB, LOCK}; localparam LOCK_MAX=16; port index type.
//  One sub-module: spram_rd_tag_pipe (RD_LAT-deep {valid,port} shift register, async reset_n).
//  Top holds FSM, rr_ptr, lock counter, grant mux.
// TESTING
//  Reset: hold reset_n=0 with both ports valid -> req_ready=00, mem_we=0, rsp_valid=00 throughout.
//  Contention: both ports read addr 0x005/0x1A0 every cycle, 8 cycles -> grants alternate 0,1,0,1...;
//   rsp_valid alternates with data from the matching address, RD_LAT cycles later.
//  Write/read: port 0 write 0x0AB data 40'h12_3456_789A, next cycle port 1 read 0x0AB ->
//   rsp_valid=10 at RD_LAT later, rsp_rdata=40'h12_3456_789A.
//  Burst lock: port 1 issues 4 writes with req_lock=1,1,1,0 while port 0 valid -> port 0 ready=0
//   for those 4 transfers, granted on the 5th cycle.
//  Starvation: port 0 lock held forever, port 1 valid -> port 1 granted after exactly 16 locked cycles.
//  Reset mid-read: issue read, assert reset_n=0 next cycle -> no rsp_valid after release.

Source files
------------

// File: rtl/spram_arb_pkg.sv
// Shared types and constants for the two-port single-port-RAM arbiter.
// The port index is a single bit because exactly two requesters share the macro.
package spram_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int LOCK_MAX   = 16;
    localparam int LOCK_CNT_W = $clog2(LOCK_MAX);

    typedef logic port_idx_t;

    function automatic port_idx_t other_port(input port_idx_t p);
        return ~p;
    endfunction

endpackage

// File: rtl/spram_rd_tag_pipe.sv
// Carries {valid, owner port} for each issued read alongside the macro's read latency,
// so the returned dataout can be steered to the port that asked for it.
module spram_rd_tag_pipe
    import spram_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      push_vld,
    input  port_idx_t push_port,
    output logic      pop_vld,
    output port_idx_t pop_port
);

    logic [RD_LAT-1:0] vld_p;
    logic [RD_LAT-1:0] port_p;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p  <= '0;
            port_p <= '0;
        end else begin
            vld_p[0]  <= push_vld;
            port_p[0] <= push_port;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i]  <= vld_p[i-1];
                port_p[i] <= port_p[i-1];
            end
        end
    end

    assign pop_vld  = vld_p[RD_LAT-1];
    assign pop_port = port_p[RD_LAT-1];

endmodule

// File: rtl/spram_port_arbiter.sv
// Round-robin arbiter with burst lock and starvation guard sharing one single-port RAM
// macro between two requesters; read data is steered back to its owner after RD_LAT cycles.
module spram_port_arbiter
    import spram_arb_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 40,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_we,
    input  logic [1:0]            req_lock,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_datain,
    output logic                  mem_we,
    input  logic [DATA_W-1:0]     mem_dataout
);

    arb_state_e              state_q, state_d;
    port_idx_t               lock_port_q, lock_port_d;
    port_idx_t               rr_ptr_q, rr_ptr_d;
    logic [LOCK_CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [ADDR_W-1:0]       last_addr_q;
    logic [DATA_W-1:0]       last_data_q;

    logic                    grant;
    port_idx_t               gnt_port;
    logic                    other_vld;
    logic [ADDR_W-1:0]       sel_addr;
    logic [DATA_W-1:0]       sel_data;
    logic                    rd_push;
    logic                    rd_pop_vld;
    port_idx_t               rd_pop_port;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ARB;
            lock_port_q <= 1'b0;
            rr_ptr_q    <= 1'b0;
            lock_cnt_q  <= '0;
            last_addr_q <= '0;
            last_data_q <= '0;
        end else begin
            state_q     <= state_d;
            lock_port_q <= lock_port_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_cnt_q  <= lock_cnt_d;
            if (grant) begin
                last_addr_q <= sel_addr;
                last_data_q <= sel_data;
            end
        end
    end

    // Grant is withheld while reset is asserted so no request can leak through during reset.
    always_comb begin
        state_d     = state_q;
        lock_port_d = lock_port_q;
        rr_ptr_d    = rr_ptr_q;
        lock_cnt_d  = lock_cnt_q;
        grant       = 1'b0;
        gnt_port    = rr_ptr_q;
        other_vld   = req_valid[other_port(lock_port_q)];
        if (reset_n) begin
            unique case (state_q)
                ARB: begin
                    if (&req_valid) begin
                        grant    = 1'b1;
                        gnt_port = rr_ptr_q;
                    end else if (req_valid[0]) begin
                        grant    = 1'b1;
                        gnt_port = 1'b0;
                    end else if (req_valid[1]) begin
                        grant    = 1'b1;
                        gnt_port = 1'b1;
                    end
                    if (grant) begin
                        rr_ptr_d = other_port(gnt_port);
                        if (req_lock[gnt_port]) begin
                            state_d     = LOCK;
                            lock_port_d = gnt_port;
                            lock_cnt_d  = '0;
                        end
                    end
                end
                LOCK: begin
                    gnt_port   = lock_port_q;
                    grant      = req_valid[lock_port_q];
                    lock_cnt_d = other_vld ? lock_cnt_q + 1'b1 : '0;
                    // Starvation guard: after LOCK_MAX waiting cycles the other port goes next.
                    if (other_vld && lock_cnt_q == LOCK_CNT_W'(LOCK_MAX - 1)) begin
                        state_d  = ARB;
                        rr_ptr_d = other_port(lock_port_q);
                    end else if (grant && !req_lock[lock_port_q]) begin
                        state_d  = ARB;
                        rr_ptr_d = other_port(lock_port_q);
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end

    assign sel_addr = gnt_port ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
    assign sel_data = gnt_port ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

    assign req_ready[0] = grant & ~gnt_port;
    assign req_ready[1] = grant &  gnt_port;

    assign mem_we     = grant & req_we[gnt_port];
    assign mem_addr   = grant ? sel_addr : last_addr_q;
    assign mem_datain = grant ? sel_data : last_data_q;

    assign rd_push = grant & ~req_we[gnt_port];

    spram_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .push_vld  (rd_push),
        .push_port (gnt_port),
        .pop_vld   (rd_pop_vld),
        .pop_port  (rd_pop_port)
    );

    assign rsp_valid[0] = rd_pop_vld & ~rd_pop_port;
    assign rsp_valid[1] = rd_pop_vld &  rd_pop_port;
    assign rsp_rdata    = mem_dataout;

endmodule
